pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_sequencer.sv | 134 +++++++++++++
 tb/tb_pipe_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Pipeline control sequencer: run/stall/flush/drain control for a 5-stage pipeline.
// Decodes ID/EX opcodes for taken branches, load-use hazards and HALT.
module pipe_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    input  logic        ex_zero,
    input  logic        mem_wait,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        take_branch,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        HALTED = 3'd3
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] stall_q, stall_d;

    logic [5:0] id_op, ex_op;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_is_r, branch_taken, load_use, id_halt;
    logic       unused_bits;

    assign id_op = id_instr[31:26];
    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];
    assign ex_op = ex_instr[31:26];
    assign ex_rt = ex_instr[20:16];
    assign unused_bits = ^{id_instr[15:0], ex_instr[25:21], ex_instr[15:0]};

    assign id_is_r      = (id_op <= 6'd5);
    assign branch_taken = ((ex_op == OP_BEQZ) && ex_zero) || ((ex_op == OP_BNEQZ) && !ex_zero);
    assign load_use     = (ex_op == OP_LW) && (ex_rt != 5'd0) &&
                          ((ex_rt == id_rs) || (id_is_r && (ex_rt == id_rt)));
    assign id_halt      = (id_op == OP_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= 2'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_d     = stall_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        take_branch = 1'b0;
        // Outputs are forced quiet while reset is asserted; registers clear at the edge.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (!mem_wait) begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                        if (branch_taken) begin
                            take_branch = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                        end else if (load_use) begin
                            pc_we      = 1'b0;
                            ifid_we    = 1'b0;
                            idex_flush = 1'b1;
                            if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                        end else if (id_halt) begin
                            pc_we      = 1'b0;
                            ifid_we    = 1'b0;
                            idex_flush = 1'b1;
                            drain_d    = 2'd3;
                            state_d    = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!mem_wait) begin
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                        if (drain_q != 2'd0) drain_d = drain_q - 2'd1;
                        // Leaving on the step that brings the counter to zero gives three drain cycles.
                        if (drain_q <= 2'd1) state_d = HALTED;
                    end
                end
                HALTED: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign state       = state_q;
    assign stall_count = stall_q;
    assign halted      = (state_q == HALTED) && !rst;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: driver pushes expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] id_instr;
    logic [31:0] ex_instr;
    logic        ex_zero;
    logic        mem_wait;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_flush, take_branch, halted;
    logic [2:0]  state;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Expected vector: {state[2:0], en[4:0], flush{ifid,idex}, take_branch, halted, stall_count[15:0]}
    logic [28:0] exp_q[$];
    string       name_q[$];

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [4:0]  EN_ALL   = 5'b11111;
    localparam logic [4:0]  EN_STALL = 5'b00111;
    localparam logic [4:0]  EN_NONE  = 5'b00000;

    pipe_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .id_instr   (id_instr),
        .ex_instr   (ex_instr),
        .ex_zero    (ex_zero),
        .mem_wait   (mem_wait),
        .pc_we      (pc_we),
        .ifid_we    (ifid_we),
        .idex_we    (idex_we),
        .exmem_we   (exmem_we),
        .memwb_we   (memwb_we),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .take_branch(take_branch),
        .halted     (halted),
        .state      (state),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    function automatic logic [28:0] vec(input logic [2:0] st, input logic [4:0] en, input logic [1:0] fl,
                                        input logic tb, input logic h, input logic [15:0] sc);
        return {st, en, fl, tb, h, sc};
    endfunction

    task automatic drive(input logic r, input logic s, input logic [31:0] id, input logic [31:0] ex,
                         input logic z, input logic mw);
        @(posedge clk);
        #1;
        rst      = r;
        start    = s;
        id_instr = id;
        ex_instr = ex;
        ex_zero  = z;
        mem_wait = mw;
    endtask

    task automatic step(input string name, input logic r, input logic s, input logic [31:0] id,
                        input logic [31:0] ex, input logic z, input logic mw, input logic [28:0] e);
        drive(r, s, id, ex, z, mw);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [28:0] got;
            logic [28:0] e;
            string       n;
            got = {state, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                   ifid_flush, idex_flush, take_branch, halted, stall_count};
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got=%h expected=%h", n, got, e);
            end
        end
    end

    logic [31:0] lw5, lw0, lw7, r_rs5, r_rs0, r_rt7, addi_rt7, halt_i, beqz, bneqz;

    initial begin
        lw5      = instr(6'b001000, 5'd1, 5'd5);
        lw0      = instr(6'b001000, 5'd1, 5'd0);
        lw7      = instr(6'b001000, 5'd2, 5'd7);
        r_rs5    = instr(6'b000000, 5'd5, 5'd2);
        r_rs0    = instr(6'b000001, 5'd0, 5'd3);
        r_rt7    = instr(6'b000101, 5'd3, 5'd7);
        addi_rt7 = instr(6'b001010, 5'd3, 5'd7);
        halt_i   = instr(6'b111111, 5'd0, 5'd0);
        beqz     = instr(6'b001110, 5'd4, 5'd0);
        bneqz    = instr(6'b001101, 5'd4, 5'd0);

        rst = 1'b1; start = 1'b0; id_instr = NOP; ex_instr = NOP; ex_zero = 1'b0; mem_wait = 1'b0;

        // Reset and start
        step("reset",       0, 0, NOP, NOP, 0, 0, vec(3'd0, EN_NONE, 2'b00, 0, 0, 16'd0));
        step("idle_start",  0, 1, NOP, NOP, 0, 0, vec(3'd0, EN_NONE, 2'b00, 0, 0, 16'd0));
        step("run",         0, 0, NOP, NOP, 0, 0, vec(3'd1, EN_ALL,  2'b00, 0, 0, 16'd0));

        // Load-use hazards
        step("lu_rs",       0, 0, r_rs5, lw5, 0, 0, vec(3'd1, EN_STALL, 2'b01, 0, 0, 16'd0));
        step("lu_count",    0, 0, NOP, NOP, 0, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'd1));
        step("lu_rt0",      0, 0, r_rs0, lw0, 0, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'd1));
        step("lu_rt_r",     0, 0, r_rt7, lw7, 0, 0, vec(3'd1, EN_STALL, 2'b01, 0, 0, 16'd1));
        step("lu_rt_i",     0, 0, addi_rt7, lw7, 0, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'd2));

        // Branches, including a HALT in ID that must be discarded
        step("br_beqz",     0, 0, halt_i, beqz, 1, 0, vec(3'd1, EN_ALL, 2'b11, 1, 0, 16'd2));
        step("br_discard",  0, 0, NOP, NOP, 0, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'd2));
        step("br_bneqz",    0, 0, r_rs5, bneqz, 0, 0, vec(3'd1, EN_ALL, 2'b11, 1, 0, 16'd2));
        step("br_bneqz_nt", 0, 0, NOP, bneqz, 1, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'd2));
        step("br_beqz_nt",  0, 0, NOP, beqz, 0, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'd2));

        // mem_wait freezes everything, including a pending hazard
        step("mw_run",      0, 0, r_rs5, lw5, 0, 1, vec(3'd1, EN_NONE, 2'b00, 0, 0, 16'd2));
        step("mw_branch",   0, 0, NOP, beqz, 1, 1, vec(3'd1, EN_NONE, 2'b00, 0, 0, 16'd2));
        step("mw_after",    0, 0, NOP, NOP, 0, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'd2));

        // HALT and drain with two wait cycles
        step("halt_detect", 0, 0, halt_i, NOP, 0, 0, vec(3'd1, EN_STALL, 2'b01, 0, 0, 16'd2));
        step("drain1",      0, 0, NOP, NOP, 0, 0, vec(3'd2, EN_STALL, 2'b00, 0, 0, 16'd2));
        step("drain_wait1", 0, 0, NOP, NOP, 0, 1, vec(3'd2, EN_NONE, 2'b00, 0, 0, 16'd2));
        step("drain_wait2", 0, 0, r_rs5, lw5, 0, 1, vec(3'd2, EN_NONE, 2'b00, 0, 0, 16'd2));
        step("drain2",      0, 0, r_rs5, lw5, 0, 0, vec(3'd2, EN_STALL, 2'b00, 0, 0, 16'd2));
        step("drain3",      0, 0, NOP, NOP, 0, 0, vec(3'd2, EN_STALL, 2'b00, 0, 0, 16'd2));
        step("halted",      0, 1, NOP, NOP, 0, 0, vec(3'd3, EN_NONE, 2'b00, 0, 1, 16'd2));
        step("halted_hold", 0, 1, r_rs5, lw5, 0, 0, vec(3'd3, EN_NONE, 2'b00, 0, 1, 16'd2));

        // Reset in the middle of DRAIN
        drive(1, 0, NOP, NOP, 0, 0);
        step("rst_idle",    0, 1, NOP, NOP, 0, 0, vec(3'd0, EN_NONE, 2'b00, 0, 0, 16'd0));
        step("rst_run",     0, 0, r_rs5, lw5, 0, 0, vec(3'd1, EN_STALL, 2'b01, 0, 0, 16'd0));
        step("rst_halt",    0, 0, halt_i, NOP, 0, 0, vec(3'd1, EN_STALL, 2'b01, 0, 0, 16'd1));
        step("rst_drain1",  0, 0, NOP, NOP, 0, 0, vec(3'd2, EN_STALL, 2'b00, 0, 0, 16'd1));
        drive(1, 0, NOP, NOP, 0, 0);
        step("rst_drain",   0, 0, NOP, NOP, 0, 0, vec(3'd0, EN_NONE, 2'b00, 0, 0, 16'd0));

        // Saturation: 65535 consecutive bubbles, then more
        step("sat_start",   0, 1, NOP, NOP, 0, 0, vec(3'd0, EN_NONE, 2'b00, 0, 0, 16'd0));
        for (int i = 0; i < 65535; i++) drive(0, 0, r_rs5, lw5, 0, 0);
        step("sat_reach",   0, 0, r_rs5, lw5, 0, 0, vec(3'd1, EN_STALL, 2'b01, 0, 0, 16'hFFFF));
        step("sat_hold",    0, 0, r_rs5, lw5, 0, 0, vec(3'd1, EN_STALL, 2'b01, 0, 0, 16'hFFFF));
        step("sat_nop",     0, 0, NOP, NOP, 0, 0, vec(3'd1, EN_ALL, 2'b00, 0, 0, 16'hFFFF));

        drive(0, 0, NOP, NOP, 0, 0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
